// File: rtl/instruction_fetch_unit.sv
// IF stage of the 5-stage MIPS pipeline: PC register, instruction-memory address and IF/ID register.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [25:0] JumpIndex,
  input  logic [31:0] InstrIn,
  output logic [31:0] InstrAddr,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] FetchCount,
  output logic [15:0] FlushCount,
  output logic [15:0] StallCount,
`endif
  output logic        FetchState
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned FCW   = 32;
  localparam int unsigned SCW   = 16;

  localparam logic [0:0] BOOT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]      state;
  logic [0:0]      state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] branch_pc;
  logic [XLEN-1:0] jump_pc;
  logic [XLEN-1:0] instr_nxt;
  logic [XLEN-1:0] pcp4_nxt;
  logic            valid_nxt;

  assign pc_plus4   = pc + XLEN'(4);
  assign branch_pc  = BranchTarget & ~XLEN'(3);
  assign jump_pc    = {IF_ID_PCPlus4[31:28], JumpIndex, 2'b00};
  assign InstrAddr  = pc;
  assign FetchState = state;

  // Next-state and next-PC selection: branch > jump > stall > sequential fetch.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = IF_ID_Instr;
    pcp4_nxt  = IF_ID_PCPlus4;
    valid_nxt = IF_ID_Valid;
    case (state)
      BOOT: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (BranchTaken) begin
          pc_nxt    = branch_pc;
          instr_nxt = NOP_WORD;
          pcp4_nxt  = '0;
          valid_nxt = 1'b0;
        end else if (Jump) begin
          pc_nxt    = jump_pc;
          instr_nxt = NOP_WORD;
          pcp4_nxt  = '0;
          valid_nxt = 1'b0;
        end else if (!Stall) begin
          pc_nxt    = pc_plus4;
          instr_nxt = InstrIn;
          pcp4_nxt  = pc_plus4;
          valid_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      IF_ID_Instr   <= NOP_WORD;
      IF_ID_PCPlus4 <= '0;
      IF_ID_Valid   <= 1'b0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      IF_ID_Instr   <= instr_nxt;
      IF_ID_PCPlus4 <= pcp4_nxt;
      IF_ID_Valid   <= valid_nxt;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic fetch_inc;
  logic flush_inc;
  logic stall_inc;

  assign fetch_inc = (state == RUN) && !BranchTaken && !Jump && !Stall;
  assign flush_inc = (state == RUN) && (BranchTaken || Jump);
  assign stall_inc = (state == RUN) && !BranchTaken && !Jump && Stall;

  // Free-running event counters, wrapping at their width.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      FetchCount <= '0;
      FlushCount <= '0;
      StallCount <= '0;
    end else begin
      if (fetch_inc) FetchCount <= FetchCount + FCW'(1);
      if (flush_inc) FlushCount <= FlushCount + SCW'(1);
      if (stall_inc) StallCount <= StallCount + SCW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [25:0] JumpIndex;
  logic [31:0] InstrIn;
  logic [31:0] InstrAddr;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic        FetchState;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCount;
  logic [15:0] FlushCount;
  logic [15:0] StallCount;
`endif

  int checks = 0;
  int errors = 0;
  logic [97:0] obs;
  logic [97:0] exp_v;

  instruction_fetch_unit dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .Jump(Jump), .JumpIndex(JumpIndex),
    .InstrIn(InstrIn), .InstrAddr(InstrAddr), .IF_ID_Instr(IF_ID_Instr),
    .IF_ID_PCPlus4(IF_ID_PCPlus4), .IF_ID_Valid(IF_ID_Valid),
`ifdef FETCH_PERF_CNT_EN
    .FetchCount(FetchCount), .FlushCount(FlushCount), .StallCount(StallCount),
`endif
    .FetchState(FetchState)
  );

  always #5 Clk = ~Clk;

  // Instruction memory model: word 0 holds addi, others encode their own address.
  always_comb begin
    if (InstrAddr == 32'h0) InstrIn = 32'h2008_0064;
    else InstrIn = {16'h8C00, InstrAddr[15:0]};
  end

  // {InstrAddr, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, FetchState}
  function automatic logic [97:0] snap();
    return {InstrAddr, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, FetchState};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0; Jump = 1'b0; JumpIndex = '0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    idle_inputs();
    tick(); tick();
    obs = snap(); exp_v = {32'h0, 32'h0, 32'h0, 1'b0, 1'b0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_state: got %h want %h", obs, exp_v); end
    Reset = 1'b1;
    tick();
    obs = snap(); exp_v = {32'h0, 32'h0, 32'h0, 1'b0, 1'b1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL boot_cycle: got %h want %h", obs, exp_v); end
    tick();
    obs = snap(); exp_v = {32'h4, 32'h2008_0064, 32'h4, 1'b1, 1'b1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL first_fetch: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_free_run();
    tick();
    obs = snap(); exp_v = {32'h8, 32'h8C00_0004, 32'h8, 1'b1, 1'b1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL run_pc8: got %h want %h", obs, exp_v); end
    tick();
    obs = snap(); exp_v = {32'hC, 32'h8C00_0008, 32'hC, 1'b1, 1'b1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL run_pcC: got %h want %h", obs, exp_v); end
    tick();
    obs = snap(); exp_v = {32'h10, 32'h8C00_000C, 32'h10, 1'b1, 1'b1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL run_pc10: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_stall();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      obs = snap(); exp_v = {32'h10, 32'h8C00_000C, 32'h10, 1'b1, 1'b1}; checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL stall_hold%0d: got %h want %h", i, obs, exp_v); end
    end
    Stall = 1'b0;
    tick();
    obs = snap(); exp_v = {32'h14, 32'h8C00_0010, 32'h14, 1'b1, 1'b1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL stall_release: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_jump();
    BranchTaken = 1'b1; BranchTarget = 32'hF4;
    tick();
    obs = snap(); exp_v = {32'hF4, 32'h0, 32'h0, 1'b0, 1'b1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL branch_to_F4: got %h want %h", obs, exp_v); end
    idle_inputs();
    tick();
    obs = snap(); exp_v = {32'hF8, 32'h8C00_00F4, 32'hF8, 1'b1, 1'b1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL fetch_F4: got %h want %h", obs, exp_v); end
    Jump = 1'b1; JumpIndex = 26'h1;
    tick();
    obs = snap(); exp_v = {32'h4, 32'h0, 32'h0, 1'b0, 1'b1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL jump_redirect: got %h want %h", obs, exp_v); end
    idle_inputs();
    tick();
    obs = snap(); exp_v = {32'h8, 32'h8C00_0004, 32'h8, 1'b1, 1'b1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL jump_target_valid: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_priority();
    BranchTaken = 1'b1; BranchTarget = 32'h43; Jump = 1'b1; JumpIndex = 26'h3FF_FFFF; Stall = 1'b1;
    tick();
    obs = snap(); exp_v = {32'h40, 32'h0, 32'h0, 1'b0, 1'b1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL branch_wins: got %h want %h", obs, exp_v); end
    idle_inputs();
    tick();
    obs = snap(); exp_v = {32'h44, 32'h8C00_0040, 32'h44, 1'b1, 1'b1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL after_branch: got %h want %h", obs, exp_v); end
    Jump = 1'b1; JumpIndex = 26'h10; Stall = 1'b1;
    tick();
    obs = snap(); exp_v = {32'h40, 32'h0, 32'h0, 1'b0, 1'b1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL jump_over_stall: got %h want %h", obs, exp_v); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFFF;
    tick();
    obs = snap(); exp_v = {32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL misaligned_target: got %h want %h", obs, exp_v); end
    idle_inputs();
    tick();
    obs = snap(); exp_v = {32'h0, 32'h8C00_FFFC, 32'h0, 1'b1, 1'b1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL pc_wrap: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_reset_midrun();
    tick();
    Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h80; Reset = 1'b0;
    tick();
    obs = snap(); exp_v = {32'h0, 32'h0, 32'h0, 1'b0, 1'b0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_midrun: got %h want %h", obs, exp_v); end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if ({FetchCount, FlushCount, StallCount} !== 64'h0) begin
      errors++; $display("FAIL perf_clear: got %h want 0", {FetchCount, FlushCount, StallCount});
    end
`endif
    Reset = 1'b1;
    tick();
    obs = snap(); exp_v = {32'h0, 32'h0, 32'h0, 1'b0, 1'b1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL boot_ignores_redirect: got %h want %h", obs, exp_v); end
    idle_inputs();
    tick();
    obs = snap(); exp_v = {32'h4, 32'h2008_0064, 32'h4, 1'b1, 1'b1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL refetch_after_reset: got %h want %h", obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_jump();
    test_priority();
    test_wrap();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
